// File: rtl/cdb_broadcaster_if.sv
// CDB broadcaster bus bundle: functional-unit result push side plus the
// two registered CDB broadcast lanes.
interface cdb_broadcaster_if #(
    parameter int unsigned NUM_SRC = 4,
    parameter int unsigned ROBEN_W = 5,
    parameter int unsigned DATA_W  = 32
);
    logic [NUM_SRC-1:0]         FU_Valid;
    logic [NUM_SRC*ROBEN_W-1:0] FU_ROBEN;
    logic [NUM_SRC*DATA_W-1:0]  FU_VAL;
    logic [NUM_SRC-1:0]         FU_Ready;
    logic [ROBEN_W-1:0]         CDB_ROBEN1;
    logic [DATA_W-1:0]          CDB_ROBEN1_VAL;
    logic [ROBEN_W-1:0]         CDB_ROBEN2;
    logic [DATA_W-1:0]          CDB_ROBEN2_VAL;
    logic [2:0]                 CDB_SRC1;
    logic [2:0]                 CDB_SRC2;

    modport master (
        output FU_Valid, FU_ROBEN, FU_VAL,
        input  FU_Ready, CDB_ROBEN1, CDB_ROBEN1_VAL, CDB_ROBEN2, CDB_ROBEN2_VAL,
               CDB_SRC1, CDB_SRC2
    );

    modport slave (
        input  FU_Valid, FU_ROBEN, FU_VAL,
        output FU_Ready, CDB_ROBEN1, CDB_ROBEN1_VAL, CDB_ROBEN2, CDB_ROBEN2_VAL,
               CDB_SRC1, CDB_SRC2
    );
endinterface

// File: rtl/cdb_broadcaster.sv
// Common data bus producer: per-source result FIFOs drained two per cycle
// onto registered CDB lanes with round-robin arbitration.
module cdb_broadcaster #(
    parameter int unsigned NUM_SRC = 4,
    parameter int unsigned DEPTH   = 2,
    parameter int unsigned ROBEN_W = 5,
    parameter int unsigned DATA_W  = 32
) (
    input logic               clk,
    input logic               rst,
    input logic               flush,
    cdb_broadcaster_if.slave  bus
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned SW = $clog2(NUM_SRC);

    logic [ROBEN_W-1:0] mem_roben [NUM_SRC][DEPTH];
    logic [DATA_W-1:0]  mem_val   [NUM_SRC][DEPTH];
    logic [PW-1:0]      rd_ptr    [NUM_SRC];
    logic [PW-1:0]      wr_ptr    [NUM_SRC];
    logic [CW-1:0]      count     [NUM_SRC];
    logic [SW-1:0]      rr_ptr;

    logic [NUM_SRC-1:0] ready;
    logic [NUM_SRC-1:0] nonempty;
    logic [NUM_SRC-1:0] push;
    logic [NUM_SRC-1:0] pop;
    logic               g1_vld;
    logic               g2_vld;
    logic [SW-1:0]      g1;
    logic [SW-1:0]      g2;

    function automatic logic [SW-1:0] wrap(input int unsigned a);
        return SW'(a % NUM_SRC);
    endfunction

    // Ready looks only at the pre-edge count: no credit for a same-cycle pop.
    always_comb begin
        ready    = '0;
        nonempty = '0;
        push     = '0;
        for (int unsigned s = 0; s < NUM_SRC; s++) begin
            ready[s]    = (count[s] != CW'(DEPTH));
            nonempty[s] = (count[s] != '0);
            push[s]     = bus.FU_Valid[s] && ready[s] &&
                          (bus.FU_ROBEN[s*ROBEN_W +: ROBEN_W] != '0);
        end
    end

    assign bus.FU_Ready = ready;

    always_comb begin
        g1_vld = 1'b0;
        g1     = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (!g1_vld && nonempty[wrap(32'(rr_ptr) + i)]) begin
                g1_vld = 1'b1;
                g1     = wrap(32'(rr_ptr) + i);
            end
        end
        g2_vld = 1'b0;
        g2     = '0;
        for (int unsigned j = 1; j < NUM_SRC; j++) begin
            if (g1_vld && !g2_vld && nonempty[wrap(32'(g1) + j)]) begin
                g2_vld = 1'b1;
                g2     = wrap(32'(g1) + j);
            end
        end
        pop = '0;
        for (int unsigned s = 0; s < NUM_SRC; s++) begin
            pop[s] = (g1_vld && g1 == SW'(s)) || (g2_vld && g2 == SW'(s));
        end
    end

    always_ff @(posedge clk) begin
        for (int unsigned s = 0; s < NUM_SRC; s++) begin
            if (push[s]) begin
                mem_roben[s][wr_ptr[s]] <= bus.FU_ROBEN[s*ROBEN_W +: ROBEN_W];
                mem_val[s][wr_ptr[s]]   <= bus.FU_VAL[s*DATA_W +: DATA_W];
            end
        end
    end

    // Flush clears everything reset does except the arbitration pointer.
    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            for (int unsigned s = 0; s < NUM_SRC; s++) begin
                rd_ptr[s] <= '0;
                wr_ptr[s] <= '0;
                count[s]  <= '0;
            end
            bus.CDB_ROBEN1     <= '0;
            bus.CDB_ROBEN1_VAL <= '0;
            bus.CDB_ROBEN2     <= '0;
            bus.CDB_ROBEN2_VAL <= '0;
            bus.CDB_SRC1       <= '0;
            bus.CDB_SRC2       <= '0;
            if (!rst) begin
                rr_ptr <= '0;
            end
        end else begin
            for (int unsigned s = 0; s < NUM_SRC; s++) begin
                if (push[s]) begin
                    wr_ptr[s] <= wr_ptr[s] + PW'(1);
                end
                if (pop[s]) begin
                    rd_ptr[s] <= rd_ptr[s] + PW'(1);
                end
                count[s] <= count[s] + CW'(push[s]) - CW'(pop[s]);
            end
            bus.CDB_ROBEN1     <= g1_vld ? mem_roben[g1][rd_ptr[g1]] : '0;
            bus.CDB_ROBEN1_VAL <= g1_vld ? mem_val[g1][rd_ptr[g1]]   : '0;
            bus.CDB_SRC1       <= g1_vld ? 3'(g1) : '0;
            bus.CDB_ROBEN2     <= g2_vld ? mem_roben[g2][rd_ptr[g2]] : '0;
            bus.CDB_ROBEN2_VAL <= g2_vld ? mem_val[g2][rd_ptr[g2]]   : '0;
            bus.CDB_SRC2       <= g2_vld ? 3'(g2) : '0;
            if (g2_vld) begin
                rr_ptr <= wrap(32'(g2) + 1);
            end else if (g1_vld) begin
                rr_ptr <= wrap(32'(g1) + 1);
            end
        end
    end
endmodule

// File: tb/tb_cdb_broadcaster.sv
// Self-checking bench for cdb_broadcaster: queue-based reference model,
// directed scenarios with literal expectations, then randomized traffic.
module tb_cdb_broadcaster;
    localparam int unsigned NS = 4;
    localparam int unsigned D  = 2;
    localparam int unsigned RW = 5;
    localparam int unsigned DW = 32;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic flush = 1'b0;
    always #5 clk = ~clk;

    logic [NS-1:0]    fv   = '0;
    logic [NS*RW-1:0] fr_p = '0;
    logic [NS*DW-1:0] fd_p = '0;

    cdb_broadcaster_if #(.NUM_SRC(NS), .ROBEN_W(RW), .DATA_W(DW)) bus ();

    assign bus.FU_Valid = fv;
    assign bus.FU_ROBEN = fr_p;
    assign bus.FU_VAL   = fd_p;

    cdb_broadcaster #(.NUM_SRC(NS), .DEPTH(D), .ROBEN_W(RW), .DATA_W(DW)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", nm, act, exp);
        end
    endtask

    // Reference model: one queue per source, round-robin pointer as an int.
    logic [RW+DW-1:0] mq [NS][$];
    int               mrr = 0;
    logic [RW-1:0]    e_r1 = '0, e_r2 = '0;
    logic [DW-1:0]    e_v1 = '0, e_v2 = '0;
    logic [2:0]       e_s1 = '0, e_s2 = '0;
    bit               accepted [NS];

    task automatic model_step();
        logic [NS-1:0] rdy;
        int g1, g2, k;
        if (!rst || flush) begin
            for (int s = 0; s < NS; s++) begin
                mq[s].delete();
                accepted[s] = 1'b0;
            end
            e_r1 = '0; e_v1 = '0; e_s1 = '0;
            e_r2 = '0; e_v2 = '0; e_s2 = '0;
            if (!rst) mrr = 0;
        end else begin
            for (int s = 0; s < NS; s++) rdy[s] = (mq[s].size() < D);
            g1 = -1;
            for (int i = 0; i < NS; i++) begin
                k = (mrr + i) % NS;
                if (g1 < 0 && mq[k].size() > 0) g1 = k;
            end
            g2 = -1;
            if (g1 >= 0) begin
                for (int j = 1; j < NS; j++) begin
                    k = (g1 + j) % NS;
                    if (g2 < 0 && mq[k].size() > 0) g2 = k;
                end
            end
            if (g1 >= 0) begin
                {e_r1, e_v1} = mq[g1].pop_front();
                e_s1 = 3'(g1);
            end else begin
                e_r1 = '0; e_v1 = '0; e_s1 = '0;
            end
            if (g2 >= 0) begin
                {e_r2, e_v2} = mq[g2].pop_front();
                e_s2 = 3'(g2);
            end else begin
                e_r2 = '0; e_v2 = '0; e_s2 = '0;
            end
            for (int s = 0; s < NS; s++) begin
                accepted[s] = fv[s] && rdy[s];
                if (fv[s] && rdy[s] && fr_p[s*RW +: RW] != '0)
                    mq[s].push_back({fr_p[s*RW +: RW], fd_p[s*DW +: DW]});
            end
            if (g2 >= 0) mrr = (g2 + 1) % NS;
            else if (g1 >= 0) mrr = (g1 + 1) % NS;
        end
    endtask

    always @(posedge clk) begin
        logic [NS-1:0] e_rdy;
        model_step();
        #1;
        for (int s = 0; s < NS; s++) e_rdy[s] = (mq[s].size() < D);
        chk("m_roben1", 64'(bus.CDB_ROBEN1), 64'(e_r1));
        chk("m_val1",   64'(bus.CDB_ROBEN1_VAL), 64'(e_v1));
        chk("m_src1",   64'(bus.CDB_SRC1), 64'(e_s1));
        chk("m_roben2", 64'(bus.CDB_ROBEN2), 64'(e_r2));
        chk("m_val2",   64'(bus.CDB_ROBEN2_VAL), 64'(e_v2));
        chk("m_src2",   64'(bus.CDB_SRC2), 64'(e_s2));
        chk("m_ready",  64'(bus.FU_Ready), 64'(e_rdy));
        if (bus.CDB_ROBEN1 != '0 && bus.CDB_ROBEN2 != '0) begin
            chk("lane_roben_distinct", 64'(bus.CDB_ROBEN1 != bus.CDB_ROBEN2), 64'd1);
            chk("lane_src_distinct",   64'(bus.CDB_SRC1 != bus.CDB_SRC2), 64'd1);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic setsrc(input int s, input logic [RW-1:0] r, input logic [DW-1:0] v);
        fv[s] = 1'b1;
        fr_p[s*RW +: RW] = r;
        fd_p[s*DW +: DW] = v;
    endtask

    task automatic chk_lanes(input string nm, input logic [RW-1:0] r1, input logic [RW-1:0] r2);
        chk({nm, "_l1"}, 64'(bus.CDB_ROBEN1), 64'(r1));
        chk({nm, "_l2"}, 64'(bus.CDB_ROBEN2), 64'(r2));
    endtask

    initial begin
        logic [RW-1:0] nextr;
        for (int s = 0; s < NS; s++) setsrc(s, RW'(s + 1), DW'(100 + s));

        // Reset held two cycles with every source valid.
        tick(); chk_lanes("rst0", 0, 0);
        tick(); chk_lanes("rst1", 0, 0);
        rst = 1'b1;
        tick(); chk_lanes("first_after_rst", 0, 0);
        chk("ready_after_rst", 64'(bus.FU_Ready), 64'hF);
        fv = '0;
        tick(); chk_lanes("rr0_pair1", 1, 2);
        chk("rr0_src1", 64'(bus.CDB_SRC1), 64'd0);
        chk("rr0_src2", 64'(bus.CDB_SRC2), 64'd1);
        tick(); chk_lanes("rr0_pair2", 3, 4);
        tick(); chk_lanes("rr0_idle", 0, 0);

        // Single result from source 2.
        setsrc(2, 5'd7, 32'hDEADBEEF);
        tick(); fv = '0;
        tick(); chk_lanes("single", 7, 0);
        chk("single_val", 64'(bus.CDB_ROBEN1_VAL), 64'hDEADBEEF);
        chk("single_src", 64'(bus.CDB_SRC1), 64'd2);
        tick(); chk_lanes("single_after", 0, 0);

        // Round robin starting from pointer 3.
        for (int s = 0; s < NS; s++) setsrc(s, RW'(s + 1), DW'(200 + s));
        tick(); fv = '0;
        tick(); chk_lanes("rr3_pair1", 4, 1);
        tick(); chk_lanes("rr3_pair2", 2, 3);
        tick();

        // ROBEN zero is dropped.
        setsrc(1, 5'd0, 32'h1234);
        tick(); fv = '0;
        chk("zero_ready", 64'(bus.FU_Ready), 64'hF);
        tick(); chk_lanes("zero_drop", 0, 0);

        // Back-to-back pushes on source 0.
        setsrc(0, 5'd9, 32'h9);
        tick(); setsrc(0, 5'd10, 32'hA);
        tick(); chk_lanes("b2b_9", 9, 0);
        chk("b2b_ready0", 64'(bus.FU_Ready[0]), 64'd1);
        setsrc(0, 5'd11, 32'hB);
        tick(); fv = '0; chk_lanes("b2b_10", 10, 0);
        tick(); chk_lanes("b2b_11", 11, 0);

        // Saturation: all sources push twice, pointer starts at 1.
        for (int s = 0; s < NS; s++) setsrc(s, RW'(12 + s), DW'(300 + s));
        tick(); chk_lanes("sat_e1", 0, 0);
        for (int s = 0; s < NS; s++) setsrc(s, RW'(16 + s), DW'(400 + s));
        tick(); chk_lanes("sat_e2", 13, 14);
        chk("sat_ready", 64'(bus.FU_Ready), 64'b0110);
        fv = '0;

        // Flush clears FIFOs and lanes but keeps the pointer at 3.
        flush = 1'b1;
        tick(); flush = 1'b0;
        chk_lanes("flush", 0, 0);
        chk("flush_ready", 64'(bus.FU_Ready), 64'hF);
        setsrc(0, 5'd20, 32'h20);
        setsrc(3, 5'd21, 32'h21);
        tick(); fv = '0;
        tick(); chk_lanes("flush_rr_held", 21, 20);

        // Randomized traffic; each FU holds its result until accepted.
        nextr = 5'd1;
        for (int s = 0; s < NS; s++) accepted[s] = 1'b1;
        for (int c = 0; c < 2000; c++) begin
            for (int s = 0; s < NS; s++) begin
                if (accepted[s] || !fv[s]) begin
                    if ($urandom_range(0, 1) == 1) begin
                        if ($urandom_range(0, 15) == 0) begin
                            setsrc(s, 5'd0, $urandom);
                        end else begin
                            setsrc(s, nextr, $urandom);
                            nextr = (nextr == 5'd31) ? 5'd1 : nextr + 5'd1;
                        end
                    end else begin
                        fv[s] = 1'b0;
                    end
                end
            end
            flush = ($urandom_range(0, 63) == 0);
            tick();
        end
        fv = '0;
        flush = 1'b0;
        repeat (6) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
